// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width constant and FSM state type for the HI/LO divider
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } divState_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] nextRem,
    output logic [WIDTH-1:0] nextQuo
);

    logic [WIDTH:0] remShift;
    logic [WIDTH:0] diff;

    // rem < divisor holds on entry, so the shifted value fits in WIDTH+1 bits
    // and a non-negative difference always fits back into WIDTH bits.
    always_comb begin
        remShift = {rem, quo[WIDTH-1]};
        diff     = remShift - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            nextRem = diff[WIDTH-1:0];
            nextQuo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            nextRem = remShift[WIDTH-1:0];
            nextQuo = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unsigned.sv
// rtl/div_unsigned.sv - sequential restoring unsigned divider, quotient to LO, remainder to HI
module div_unsigned
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] division_hi_rem,
    output logic [WIDTH-1:0] division_lo_quo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    divState_t      state;
    divState_t      nextState;
    logic [CW-1:0]  count;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic           doneReg;
    logic           dbzReg;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic           lastStep;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (remReg),
        .quo     (quoReg),
        .divisor (divisorReg),
        .nextRem (stepRem),
        .nextQuo (stepQuo)
    );

    assign lastStep = (state == RUN) && (count == LAST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (lastStep) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // quoReg starts as the dividend and is shifted out MSB-first while quotient bits shift in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
            dbzReg     <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        quoReg     <= dividend;
                        divisorReg <= divisor;
                        remReg     <= '0;
                        count      <= '0;
                    end
                end
                RUN: begin
                    remReg <= stepRem;
                    quoReg <= stepQuo;
                    count  <= count + 1'b1;
                    if (lastStep) begin
                        hiReg   <= stepRem;
                        loReg   <= stepQuo;
                        doneReg <= 1'b1;
                        dbzReg  <= (divisorReg == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state == RUN);
    assign done            = doneReg;
    assign div_by_zero     = dbzReg;
    assign division_hi_rem = hiReg;
    assign division_lo_quo = loReg;

endmodule

// File: tb/tb_div_unsigned.sv
// tb/tb_div_unsigned.sv - scoreboard bench for div_unsigned with directed vectors
module tb_div_unsigned;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] division_hi_rem;
    logic [W-1:0] division_lo_quo;

    exp_t q[$];
    int   cyc = 0;
    int   nCmp = 0;
    int   nBad = 0;

    div_unsigned #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dividend        (dividend),
        .divisor         (divisor),
        .busy            (busy),
        .done            (done),
        .div_by_zero     (div_by_zero),
        .division_hi_rem (division_hi_rem),
        .division_lo_quo (division_lo_quo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("lo_quo", 64'(division_lo_quo), 64'(e.lo));
                check("hi_rem", 64'(division_hi_rem), 64'(e.hi));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                         input logic expDbz);
        exp_t e;
        e.hi  = expHi;
        e.lo  = expLo;
        e.dbz = expDbz;
        e.cyc = cyc + 1 + W;
        q.push_back(e);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(division_hi_rem), 64'd0);
        check("rst_lo", 64'(division_lo_quo), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_hi", 64'(division_hi_rem), 64'd0);
        check("idle_lo", 64'(division_lo_quo), 64'd0);

        issue(32'd34, 32'd5, 32'd4, 32'd6, 1'b0);
        waitDone();
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);

        issue(32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
        waitDone();
        @(negedge clk);
        issue(32'd7, 32'hFFFF_FFFF, 32'd7, 32'd0, 1'b0);
        waitDone();
        @(negedge clk);
        issue(32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        waitDone();
        @(negedge clk);
        check("dbz_held", 64'(div_by_zero), 64'd1);
        issue(32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
        waitDone();
        @(negedge clk);

        // start while busy is ignored and HI/LO keep the previous result
        issue(32'd34, 32'd5, 32'd4, 32'd6, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_lo", 64'(division_lo_quo), 64'd3);
        check("hold_hi", 64'(division_hi_rem), 64'd0);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd7;
        repeat (3) @(negedge clk);
        start = 1'b0;
        waitDone();
        // back-to-back start issued in the done cycle
        issue(32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);
        waitDone();
        @(negedge clk);

        // reset mid-run aborts without a done pulse
        issue(32'd500, 32'd3, 32'd2, 32'd166, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(division_hi_rem), 64'd0);
        check("abort_lo", 64'(division_lo_quo), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 8) @(negedge clk);
        issue(32'd34, 32'd5, 32'd4, 32'd6, 1'b0);
        waitDone();
        repeat (2) @(negedge clk);
        check("pending_results", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
